// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory bus, consumer handshake and redirect port of the fetch queue.
interface fetch_queue_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc,
      input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );
   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc,
      output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction prefetcher feeding a DEPTH-entry queue with registered head.
// Optional FETCH_QUEUE_STALL_COUNT_EN adds o_stall_count (saturating count of cycles without a valid head).
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic            i_clk,
   input logic            i_rst_n,
   fetch_queue_if.master  io_bus
`ifdef FETCH_QUEUE_STALL_COUNT_EN
   ,
   output logic [31:0]    o_stall_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
   state_t        r_state, w_state_nxt;
   logic [31:0]   r_pc, r_addr, r_instr, r_instr_pc;
   logic          r_valid;
   logic [31:0]   r_mem_instr [DEPTH];
   logic [31:0]   r_mem_pc [DEPTH];
   logic [AW-1:0] r_rd, r_wr, w_rd_nxt;
   logic [AW:0]   r_cnt, w_cnt_pop, w_cnt_nxt;
   logic          w_pop, w_ack, w_push, w_issue;
   logic [31:0]   w_head_instr, w_head_pc;
   assign w_pop     = r_valid & io_bus.instr_ready;
   assign w_ack     = io_bus.mem_ack & (r_state == WAIT);
   assign w_push    = w_ack & ~io_bus.redirect;
   assign w_cnt_pop = r_cnt - (AW+1)'(w_pop);
   assign w_cnt_nxt = w_cnt_pop + (AW+1)'(w_push);
   assign w_rd_nxt  = r_rd + AW'(w_pop);
   assign w_issue   = ~io_bus.redirect & ((r_state == IDLE) | w_ack) & (w_cnt_nxt < FULL);
   // a word pushed into an otherwise empty queue bypasses the array straight to the head
   assign w_head_instr = (w_cnt_pop == '0) ? io_bus.mem_rdata : r_mem_instr[w_rd_nxt];
   assign w_head_pc    = (w_cnt_pop == '0) ? r_addr : r_mem_pc[w_rd_nxt];
   always_comb begin
      w_state_nxt = r_state;
      if (w_issue) w_state_nxt = WAIT;
      else if (r_state == IDLE) w_state_nxt = IDLE;
      else if (io_bus.mem_ack) w_state_nxt = IDLE;
      else if (io_bus.redirect) w_state_nxt = DISCARD;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_addr     <= RESET_PC;
         r_rd       <= '0;
         r_wr       <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (io_bus.redirect) begin
            r_pc    <= {io_bus.redirect_pc[31:2], 2'b00};
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
         end else begin
            r_rd    <= w_rd_nxt;
            r_wr    <= r_wr + AW'(w_push);
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_cnt_nxt != '0;
            if (w_push) r_pc <= r_addr + 32'd4;
            if (w_cnt_nxt != '0) begin
               r_instr    <= w_head_instr;
               r_instr_pc <= w_head_pc;
            end
         end
         if (w_issue) r_addr <= w_push ? r_addr + 32'd4 : r_pc;
      end
   end
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem_instr[r_wr] <= io_bus.mem_rdata;
         r_mem_pc[r_wr]    <= r_addr;
      end
   end
`ifdef FETCH_QUEUE_STALL_COUNT_EN
   logic [31:0] r_stall;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_stall <= '0;
      else if (!r_valid && r_stall != 32'hFFFF_FFFF) r_stall <= r_stall + 32'd1;
   end
   assign o_stall_count = r_stall;
`endif
   assign io_bus.mem_req     = r_state != IDLE;
   assign io_bus.mem_addr    = r_addr;
   assign io_bus.instr_valid = r_valid;
   assign io_bus.instr       = r_instr;
   assign io_bus.instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus against a queue-level reference model of the fetch queue.
module tb_fetch_queue;
   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   fetch_queue_if bus();
`ifdef FETCH_QUEUE_STALL_COUNT_EN
   logic [31:0] stall_count;
   logic [31:0] m_stall;
   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus), .o_stall_count(stall_count));
`else
   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));
`endif
   always #5 clk = ~clk;
   logic [63:0] q[$];
   logic [63:0] m_hold;
   logic        m_req, m_disc;
   logic [31:0] m_pc, m_addr;
   int          m_age;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, m_req});
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, q.size() > 0});
      chk("instr", bus.instr, m_hold[31:0]);
      chk("instr_pc", bus.instr_pc, m_hold[63:32]);
`ifdef FETCH_QUEUE_STALL_COUNT_EN
      chk("stall_count", stall_count, m_stall);
`endif
   endtask
   task automatic do_reset();
      bus.mem_ack = 1'b0;
      bus.redirect = 1'b0;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_hold = '0;
      m_req = 1'b0;
      m_disc = 1'b0;
      m_pc = RESET_PC;
      m_addr = RESET_PC;
      m_age = 0;
`ifdef FETCH_QUEUE_STALL_COUNT_EN
      m_stall = '0;
`endif
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic cyc(input logic ack, input logic [31:0] rdata, input logic ready, input logic redir, input logic [31:0] rpc);
      logic was_idle, was_wait, was_disc, pop, acked, issued;
      bus.mem_ack = ack;
      bus.mem_rdata = rdata;
      bus.instr_ready = ready;
      bus.redirect = redir;
      bus.redirect_pc = rpc;
      @(posedge clk);
`ifdef FETCH_QUEUE_STALL_COUNT_EN
      if (q.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
      was_idle = !m_req;
      was_wait = m_req && !m_disc;
      was_disc = m_req && m_disc;
      pop = (q.size() > 0) && ready;
      acked = was_wait && ack;
      issued = 1'b0;
      if (redir) begin
         q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
         if (m_req) begin
            if (ack) begin
               m_req = 1'b0;
               m_disc = 1'b0;
            end else m_disc = 1'b1;
         end
      end else begin
         if (pop) void'(q.pop_front());
         if (was_disc && ack) begin
            m_req = 1'b0;
            m_disc = 1'b0;
         end
         if (acked) begin
            q.push_back({m_addr, rdata});
            m_pc = m_addr + 32'd4;
            m_req = 1'b0;
         end
         if ((was_idle || acked) && q.size() < DEPTH) begin
            m_req = 1'b1;
            m_addr = m_pc;
            issued = 1'b1;
         end
      end
      if (q.size() > 0) m_hold = q[0];
      m_age = issued ? 0 : (m_req ? m_age + 1 : 0);
      #1 check_all();
   endtask
   function automatic logic dack();
      return m_req && m_age >= 1;
   endfunction
   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      bus.instr_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      // ack one cycle after each request, consumer always ready
      do_reset();
      repeat (14) cyc(dack(), $urandom, 1'b1, 1'b0, 32'h0);
      // consumer stalled: queue fills and requests stop
      do_reset();
      repeat (20) cyc(dack(), $urandom, 1'b0, 1'b0, 32'h0);
      chk("full_req", {31'b0, bus.mem_req}, 32'd0);
      chk("full_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("full_head_pc", bus.instr_pc, 32'h0);
      // redirect while a request is outstanding
      do_reset();
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
      cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
      chk("discard_valid", {31'b0, bus.instr_valid}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("redir_addr", bus.mem_addr, 32'h0000_0100);
      cyc(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
      chk("redir_head_pc", bus.instr_pc, 32'h0000_0100);
      // address wrap at the top of memory
      do_reset();
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (5) cyc(dack(), $urandom, 1'b0, 1'b0, 32'h0);
      chk("wrap_head_pc", bus.instr_pc, 32'hFFFF_FFF8);
      chk("wrap_next_addr", bus.mem_addr, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("wrap_second_pc", bus.instr_pc, 32'hFFFF_FFFC);
      // reset mid-request, then a stray ack
      do_reset();
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("pre_reset_req", {31'b0, bus.mem_req}, 32'd1);
      do_reset();
      cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      chk("stray_valid", {31'b0, bus.instr_valid}, 32'd0);
      chk("stray_addr", bus.mem_addr, RESET_PC);
      // random traffic including stray acks and redirects
      repeat (400) cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 MEM_REQ  output  1  instruction-memory fetch request.
REQ-006 MEM_ADDR  output  32  fetch address, word aligned.
REQ-007 MEM_ACK  input  1  memory response valid this cycle; completes the outstanding request.
REQ-008 MEM_RDATA  input  32  instruction word, valid when MEM_ACK=1.
REQ-009 INSTR_VALID  output  1  queue head holds a valid instruction.
REQ-010 INSTR  output  32  queue head instruction word.
REQ-011 INSTR_PC  output  32  address of INSTR.
REQ-012 INSTR_READY  input  1  consumer (core decode/PC stage) accepts head this cycle.
REQ-013 REDIRECT  input  1  branch/jump taken; discard all fetched and in-flight instructions.
REQ-014 REDIRECT_PC  input  32  new fetch address, sampled when REDIRECT=1.

Function
REQ-015 The block SHALL keep at most one memory request outstanding.
REQ-016 The block SHALL use FSM states IDLE (no request), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-017 IDLE->WAIT SHALL occur when occupancy + 1 <= DEPTH after this cycle's pop, with MEM_REQ=1 and MEM_ADDR=fetch PC.
REQ-018 MEM_REQ and MEM_ADDR SHALL remain stable from assertion until the cycle MEM_ACK=1; the request is never retracted.
REQ-019 On MEM_ACK in WAIT: push {MEM_RDATA, MEM_ADDR}, fetch PC += 4 (wraps 32'hFFFF_FFFC -> 0), go to IDLE or reissue immediately next cycle if space remains.
REQ-020 MEM_ACK outside WAIT/DISCARD SHALL be ignored.
REQ-021 A pushed word SHALL appear on INSTR/INSTR_PC with INSTR_VALID=1 the cycle after MEM_ACK (1-cycle latency); outputs are registered.
REQ-022 Pop occurs when INSTR_VALID=1 and INSTR_READY=1; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 Queue full SHALL block new requests; empty SHALL hold INSTR_VALID=0 with INSTR/INSTR_PC unchanged.
REQ-024 REDIRECT SHALL take priority over push, pop and ack in its cycle: queue flushed, INSTR_VALID=0 next cycle, fetch PC <= {REDIRECT_PC[31:2], 2'b00}.
REQ-025 REDIRECT in WAIT without MEM_ACK SHALL go to DISCARD; REDIRECT with MEM_ACK SHALL drop the data and go to IDLE.
REQ-026 In DISCARD, the ack'd data SHALL be dropped and the FSM go to IDLE; a further REDIRECT in DISCARD only updates fetch PC.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy never exceeds DEPTH.

Reset
REQ-028 RESET_N=0 SHALL immediately force: FSM IDLE, queue empty, fetch PC=RESET_PC, MEM_REQ=0, MEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR=0, INSTR_PC=0.
REQ-029 Reset mid-request SHALL abandon the request; the first MEM_ACK after reset release without a new request SHALL be ignored.
REQ-030 The first request SHALL issue on the first rising edge after RESET_N deasserts.

Configuration
REQ-031 Macro FETCH_QUEUE_STALL_COUNT_EN SHALL, when defined, add output STALL_COUNT (32) counting cycles with INSTR_VALID=0 and RESET_N=1, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-032 Without FETCH_QUEUE_STALL_COUNT_EN, the STALL_COUNT port and counter SHALL not exist and all other behaviour is identical.

Verification
REQ-033 Reset release, memory acks every request 1 cycle after, INSTR_READY=1 -> INSTR_PC sequence 0x0,0x4,0x8,... with one instruction per 2 cycles.
REQ-034 INSTR_READY=0, DEPTH=4 -> exactly 4 acks accepted, MEM_REQ stays 0 with queue full; INSTR_PC head stays 0x0.
REQ-035 REDIRECT=1, REDIRECT_PC=0x0000_0103 while in WAIT -> next MEM_ACK data dropped, next MEM_ADDR=0x0000_0100, INSTR_VALID=0 until its ack.
REQ-036 RESET_PC=0xFFFF_FFF8, two acks -> INSTR_PC 0xFFFF_FFF8 then 0xFFFF_FFFC, next MEM_ADDR=0x0.
REQ-037 RESET_N pulsed low while MEM_REQ=1, then stray MEM_ACK with data 0xDEAD_BEEF -> outputs at reset values, no push, fresh request at RESET_PC.
REQ-038 With FETCH_QUEUE_STALL_COUNT_EN, memory ack delayed 5 cycles from reset -> STALL_COUNT=6 when first INSTR_VALID rises.
